// File: rtl/atanh_iter_pkg.sv
// Shared NN definitions: Q3.12 constants, tanh latency, FSM states and the tanh breakpoint table.
package atanh_iter_pkg;

  localparam int unsigned FRAC_BITS = 12;
  localparam logic [15:0] ONE       = 16'h1000;
  localparam logic [15:0] SAT_POS   = 16'h7FFF;
  localparam logic [15:0] SAT_NEG   = 16'h8001;
  localparam int unsigned TANH_LAT  = 5;

  typedef enum logic [2:0] {
    StIdle, StSat, StZero, StIssue, StWait, StCmp, StDone
  } state_e;

  // round(4096 * tanh(k / 16)) for k = 0..64, i.e. breakpoints every 1/16 over [0, 4]
  localparam logic [11:0] TANH_TAB [65] = '{
    12'd0,    12'd256,  12'd509,  12'd759,  12'd1003, 12'd1240, 12'd1468, 12'd1686,
    12'd1893, 12'd2088, 12'd2272, 12'd2443, 12'd2602, 12'd2748, 12'd2883, 12'd3007,
    12'd3119, 12'd3222, 12'd3315, 12'd3399, 12'd3475, 12'd3543, 12'd3604, 12'd3659,
    12'd3707, 12'd3751, 12'd3790, 12'd3825, 12'd3856, 12'd3883, 12'd3908, 12'd3929,
    12'd3949, 12'd3966, 12'd3981, 12'd3994, 12'd4006, 12'd4016, 12'd4026, 12'd4034,
    12'd4041, 12'd4048, 12'd4053, 12'd4058, 12'd4063, 12'd4067, 12'd4070, 12'd4073,
    12'd4076, 12'd4078, 12'd4080, 12'd4082, 12'd4084, 12'd4085, 12'd4086, 12'd4088,
    12'd4089, 12'd4089, 12'd4090, 12'd4091, 12'd4091, 12'd4092, 12'd4092, 12'd4093,
    12'd4093
  };

endpackage

// File: rtl/atanh_iter_tanh.sv
// Five-stage Q3.12 tanh: odd-symmetric piecewise-linear interpolation over 64 segments on [0, 4).
module atanh_iter_tanh
  import atanh_iter_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [15:0] din_i,
  output logic [15:0] dout_o
);

  localparam logic [15:0] XMax = ONE << 2;

  logic [15:0] mag;
  logic        sign_q1, sign_q2, sign_q3, sign_q4;
  logic        sat_q1, sat_q2, sat_q3;
  logic [13:0] mag_q1;
  logic [11:0] t0_q2, t0_q3, y_q4;
  logic [8:0]  dt_q2;
  logic [7:0]  frac_q2;
  logic [16:0] prod_q3;
  logic [11:0] t0_lut, t1_lut;

  assign mag    = din_i[15] ? (~din_i + 16'd1) : din_i;
  assign t0_lut = TANH_TAB[{1'b0, mag_q1[13:8]}];
  assign t1_lut = TANH_TAB[{1'b0, mag_q1[13:8]} + 7'd1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sign_q1 <= 1'b0;
      sign_q2 <= 1'b0;
      sign_q3 <= 1'b0;
      sign_q4 <= 1'b0;
      sat_q1  <= 1'b0;
      sat_q2  <= 1'b0;
      sat_q3  <= 1'b0;
      mag_q1  <= '0;
      t0_q2   <= '0;
      t0_q3   <= '0;
      dt_q2   <= '0;
      frac_q2 <= '0;
      prod_q3 <= '0;
      y_q4    <= '0;
      dout_o  <= '0;
    end else begin
      if (en_i) begin
        sign_q1 <= din_i[15];
        sat_q1  <= (mag >= XMax);
        mag_q1  <= mag[13:0];
      end
      sign_q2 <= sign_q1;
      sat_q2  <= sat_q1;
      t0_q2   <= t0_lut;
      dt_q2   <= 9'(t1_lut - t0_lut);
      frac_q2 <= mag_q1[7:0];
      sign_q3 <= sign_q2;
      sat_q3  <= sat_q2;
      t0_q3   <= t0_q2;
      prod_q3 <= 17'(dt_q2) * 17'(frac_q2);
      sign_q4 <= sign_q3;
      // Beyond 4.0 the curve is flat to within a couple of LSBs; hold the last breakpoint.
      y_q4    <= sat_q3 ? TANH_TAB[7'd64] : t0_q3 + 12'((prod_q3 + 17'd128) >> 8);
      dout_o  <= sign_q4 ? -{4'b0, y_q4} : {4'b0, y_q4};
    end
  end

endmodule

// File: rtl/atanh_iter.sv
// Q3.12 atanh by 14-step bisection over x in [0, 4), using the hardware tanh as the forward model.
module atanh_iter #(
  parameter int unsigned ITER      = 14,
  parameter int unsigned TANH_LAT  = atanh_iter_pkg::TANH_LAT,
  parameter int unsigned FRAC_BITS = atanh_iter_pkg::FRAC_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        en,
  output logic        busy,
  output logic [15:0] dout,
  output logic        valid
);
  import atanh_iter_pkg::*;

  localparam int unsigned BitW = $clog2(ITER);
  localparam int unsigned CntW = $clog2(TANH_LAT);

  state_e          state_q;
  logic            sign_q;
  logic [15:0]     a_q, x_q;
  logic [BitW-1:0] bit_q;
  logic [CntW-1:0] cnt_q;

  logic [15:0] mag, cand, tanh_y, tanh_pos, x_next;
  logic        tanh_en;

  assign mag      = (din == 16'h8000) ? 16'h7FFF : (din[15] ? -din : din);
  assign cand     = x_q | (16'd1 << bit_q);
  assign tanh_en  = (state_q == StIssue);
  assign tanh_pos = tanh_y[15] ? 16'd0 : tanh_y;
  assign x_next   = (tanh_pos <= a_q) ? cand : x_q;

  atanh_iter_tanh u_tanh (
    .clk_i  (clk),
    .rst_ni (1'b1),
    .en_i   (tanh_en),
    .din_i  (cand),
    .dout_o (tanh_y)
  );

  // Compare timing comes only from cnt_q, so stale tanh results after a reset are never used.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sign_q  <= 1'b0;
      a_q     <= '0;
      x_q     <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      dout    <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (en) begin
            sign_q <= din[15];
            a_q    <= mag;
            busy   <= 1'b1;
            if (mag[15:FRAC_BITS] != '0) begin
              state_q <= StSat;
              dout    <= din[15] ? SAT_NEG : SAT_POS;
              valid   <= 1'b1;
            end else if (mag == '0) begin
              state_q <= StZero;
              dout    <= '0;
              valid   <= 1'b1;
            end else begin
              state_q <= StIssue;
              x_q     <= '0;
              bit_q   <= BitW'(ITER - 1);
            end
          end
        end
        StSat, StZero, StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        StIssue: begin
          cnt_q   <= CntW'(TANH_LAT - 1);
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == CntW'(1)) begin
            state_q <= StCmp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StCmp: begin
          x_q <= x_next;
          if (bit_q == '0) begin
            dout    <= sign_q ? -x_next : x_next;
            valid   <= 1'b1;
            state_q <= StDone;
          end else begin
            bit_q   <= bit_q - 1'b1;
            state_q <= StIssue;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
